ppu_timing_gen: RTL and testbench

- Parametrised successor to the PPU render controller: dot/line counters, frame parity and registered render strobes.
- New over the previous generation:
  - selectable NTSC/PAL frame geometry, latched per frame;
  - frame counter;
  - programmable scanline-compare pulse.
- Sits between the PPU register file and the background/sprite fetch pipelines.
- Runs on the PPU clock domain, advancing only on clock_EN.

---
 rtl/ppu_timing_pkg.sv | 16 +
 rtl/ppu_dot_counter.sv | 53 +++++
 rtl/ppu_timing_gen.sv | 89 ++++++++
 tb/tb_ppu_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_timing_pkg.sv
// ppu_timing_pkg: shared dot constants, counter types and video standard enum
package ppu_timing_pkg;
  localparam int DOT_W = 9;
  localparam int LINE_W = 9;
  typedef logic [DOT_W-1:0] dot_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef enum logic {NTSC = 1'b0, PAL = 1'b1} video_std_e;
  localparam dot_t DOT_VIS_END = dot_t'(256);
  localparam dot_t DOT_HCOPY = dot_t'(257);
  localparam dot_t DOT_MATCH = dot_t'(260);
  localparam dot_t DOT_VCOPY_LO = dot_t'(280);
  localparam dot_t DOT_VCOPY_HI = dot_t'(304);
  localparam dot_t DOT_SPR_END = dot_t'(320);
  localparam dot_t DOT_PF0 = dot_t'(328);
  localparam dot_t DOT_PF1 = dot_t'(336);
endpackage

// File: rtl/ppu_dot_counter.sv
// ppu_dot_counter: dot/line counters, frame parity, frame count and per-frame geometry latch
module ppu_dot_counter
  import ppu_timing_pkg::*;
#(
  parameter int DOTS_PER_LINE = 341,
  parameter int NTSC_LINES = 262,
  parameter int PAL_LINES = 312,
  parameter int X_W = 9,
  parameter int Y_W = 9,
  parameter int FRAME_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_EN,
  input  logic pal_mode,
  input  logic render,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic odd_frame,
  output logic [FRAME_W-1:0] frame_count,
  output logic pal_active,
  output logic [Y_W-1:0] last
);
  localparam logic [X_W-1:0] X_LAST = X_W'(DOTS_PER_LINE - 1);
  localparam logic [Y_W-1:0] NTSC_LAST = Y_W'(NTSC_LINES - 1);
  localparam logic [Y_W-1:0] PAL_LAST = Y_W'(PAL_LINES - 1);
  video_std_e std;
  assign pal_active = std == PAL;
  assign last = pal_active ? PAL_LAST : NTSC_LAST;
  // advance dot/line; at frame wrap toggle parity, count, latch geometry and apply the NTSC odd-frame dot skip
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      odd_frame <= 1'b0;
      frame_count <= '0;
      std <= video_std_e'(pal_mode);
    end else if (clock_EN) begin
      if (x != X_LAST) begin
        x <= x + 1'b1;
      end else if (y != last) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= (odd_frame && render && !pal_active) ? X_W'(1) : '0;
        y <= '0;
        odd_frame <= ~odd_frame;
        frame_count <= frame_count + 1'b1;
        std <= video_std_e'(pal_mode);
      end
    end
  end
endmodule

// File: rtl/ppu_timing_gen.sv
// ppu_timing_gen: PPU dot/line timing with registered render strobes and scanline compare
module ppu_timing_gen
  import ppu_timing_pkg::*;
#(
  parameter int DOTS_PER_LINE = 341,
  parameter int VISIBLE_LINES = 240,
  parameter int NTSC_LINES = 262,
  parameter int PAL_LINES = 312,
  parameter int X_W = 9,
  parameter int Y_W = 9,
  parameter int FRAME_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_EN,
  input  logic pal_mode,
  input  logic background_EN,
  input  logic sprite_EN,
  input  logic cmp_EN,
  input  logic [Y_W-1:0] cmp_line,
  output logic [X_W-1:0] xPos,
  output logic [Y_W-1:0] yPos,
  output logic oddFrame,
  output logic [FRAME_W-1:0] frameCount,
  output logic palActive,
  output logic setVBlank,
  output logic clearVBlank,
  output logic incrementX,
  output logic incrementY,
  output logic resetX,
  output logic resetY,
  output logic backgroundFetch_EN,
  output logic spriteFetch_EN,
  output logic idle,
  output logic lineMatch
);
  logic [Y_W-1:0] last;
  logic render, on_last, active, x_one;
  assign render = background_EN | sprite_EN;
  assign on_last = yPos == last;
  assign active = yPos < Y_W'(VISIBLE_LINES) || on_last;
  assign x_one = xPos == X_W'(1);
  ppu_dot_counter #(
    .DOTS_PER_LINE(DOTS_PER_LINE),
    .NTSC_LINES(NTSC_LINES),
    .PAL_LINES(PAL_LINES),
    .X_W(X_W),
    .Y_W(Y_W),
    .FRAME_W(FRAME_W)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clock_EN(clock_EN),
    .pal_mode(pal_mode),
    .render(render),
    .x(xPos),
    .y(yPos),
    .odd_frame(oddFrame),
    .frame_count(frameCount),
    .pal_active(palActive),
    .last(last)
  );
  // strobes decode the pre-update position, so each lags its dot by one enable and holds between enables
  always_ff @(posedge clock) begin
    if (reset) begin
      setVBlank <= 1'b0;
      clearVBlank <= 1'b0;
      incrementX <= 1'b0;
      incrementY <= 1'b0;
      resetX <= 1'b0;
      resetY <= 1'b0;
      backgroundFetch_EN <= 1'b0;
      spriteFetch_EN <= 1'b0;
      idle <= 1'b0;
      lineMatch <= 1'b0;
    end else if (clock_EN) begin
      clearVBlank <= x_one && on_last;
      setVBlank <= x_one && yPos == Y_W'(VISIBLE_LINES + 1);
      incrementX <= background_EN && active && ((xPos[2:0] == 3'd0 && xPos != '0 && xPos <= DOT_VIS_END) || xPos == DOT_PF0 || xPos == DOT_PF1);
      incrementY <= background_EN && active && xPos == DOT_VIS_END;
      resetX <= background_EN && active && xPos == DOT_HCOPY;
      resetY <= background_EN && on_last && xPos >= DOT_VCOPY_LO && xPos <= DOT_VCOPY_HI;
      backgroundFetch_EN <= background_EN && active && xPos != '0 && (xPos < DOT_HCOPY || xPos > DOT_SPR_END);
      spriteFetch_EN <= sprite_EN && active && xPos >= DOT_HCOPY && xPos <= DOT_SPR_END;
      idle <= xPos == '0;
      lineMatch <= cmp_EN && render && xPos == DOT_MATCH && yPos == cmp_line;
    end
  end
endmodule

// File: tb/tb_ppu_timing_gen.sv
// tb_ppu_timing_gen: frame-level scoreboard for ppu_timing_gen using a shortened frame geometry
module tb_ppu_timing_gen;
  localparam int V = 6;
  localparam int NL = 9;
  localparam int PL = 11;
  localparam int DPL = 341;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clock_EN = 1'b0;
  logic pal_mode = 1'b0;
  logic background_EN = 1'b0;
  logic sprite_EN = 1'b0;
  logic cmp_EN = 1'b0;
  logic [8:0] cmp_line = '0;
  logic [8:0] xPos, yPos;
  logic oddFrame, palActive;
  logic [7:0] frameCount;
  logic setVBlank, clearVBlank, incrementX, incrementY, resetX, resetY;
  logic backgroundFetch_EN, spriteFetch_EN, idle, lineMatch;
  always #5 clock = ~clock;
  ppu_timing_gen #(
    .DOTS_PER_LINE(DPL),
    .VISIBLE_LINES(V),
    .NTSC_LINES(NL),
    .PAL_LINES(PL),
    .X_W(9),
    .Y_W(9),
    .FRAME_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .clock_EN(clock_EN),
    .pal_mode(pal_mode),
    .background_EN(background_EN),
    .sprite_EN(sprite_EN),
    .cmp_EN(cmp_EN),
    .cmp_line(cmp_line),
    .xPos(xPos),
    .yPos(yPos),
    .oddFrame(oddFrame),
    .frameCount(frameCount),
    .palActive(palActive),
    .setVBlank(setVBlank),
    .clearVBlank(clearVBlank),
    .incrementX(incrementX),
    .incrementY(incrementY),
    .resetX(resetX),
    .resetY(resetY),
    .backgroundFetch_EN(backgroundFetch_EN),
    .spriteFetch_EN(spriteFetch_EN),
    .idle(idle),
    .lineMatch(lineMatch)
  );
  typedef struct {
    int len, idle, incx, incy, rstx, rsty, bgf, spf, setvb, clrvb, match;
    int sv_pos, cv_pos, lm_pos, x_after, fc, odd, pal;
  } frame_t;
  frame_t q[$];
  frame_t acc;
  int checks = 0;
  int failures = 0;
  int prev_fc = 0;
  logic en_q = 1'b0;
  logic rst_q = 1'b0;
  logic pal_q = 1'b0;
  logic [9:0] strobes;
  logic [37:0] outs, snap;
  assign strobes = {setVBlank, clearVBlank, incrementX, incrementY, resetX, resetY, backgroundFetch_EN, spriteFetch_EN, idle, lineMatch};
  assign outs = {xPos, yPos, oddFrame, frameCount, palActive, strobes};
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic cmp_frame(frame_t a, frame_t e);
    chk("frame_len", a.len, e.len);
    chk("idle_count", a.idle, e.idle);
    chk("incx_count", a.incx, e.incx);
    chk("incy_count", a.incy, e.incy);
    chk("resetx_count", a.rstx, e.rstx);
    chk("resety_count", a.rsty, e.rsty);
    chk("bgfetch_count", a.bgf, e.bgf);
    chk("sprfetch_count", a.spf, e.spf);
    chk("setvb_count", a.setvb, e.setvb);
    chk("clrvb_count", a.clrvb, e.clrvb);
    chk("match_count", a.match, e.match);
    chk("setvb_pos", a.sv_pos, e.sv_pos);
    chk("clrvb_pos", a.cv_pos, e.cv_pos);
    chk("match_pos", a.lm_pos, e.lm_pos);
    chk("wrap_x", a.x_after, e.x_after);
    chk("wrap_frame_count", a.fc, e.fc);
    chk("wrap_odd", a.odd, e.odd);
    chk("wrap_pal", a.pal, e.pal);
  endtask
  function automatic frame_t ef(int lines, bit bg, bit sp, bit skip, int my, int fc, bit odd, bit pal, int xa);
    frame_t f;
    f = '{default: 0};
    f.len = lines * DPL - int'(skip);
    f.idle = lines - int'(skip);
    f.incx = bg ? 34 * (V + 1) : 0;
    f.incy = bg ? V + 1 : 0;
    f.rstx = bg ? V + 1 : 0;
    f.rsty = bg ? 25 : 0;
    f.bgf = bg ? 276 * (V + 1) : 0;
    f.spf = sp ? 64 * (V + 1) : 0;
    f.setvb = 1;
    f.sv_pos = (V + 1) * 1000 + 2;
    f.clrvb = 1;
    f.cv_pos = (lines - 1) * 1000 + 2;
    f.match = my >= 0 ? 1 : 0;
    f.lm_pos = my >= 0 ? my * 1000 + 261 : 0;
    f.fc = fc;
    f.odd = int'(odd);
    f.pal = int'(pal);
    f.x_after = xa;
    return f;
  endfunction
  always @(posedge clock) begin
    en_q <= clock_EN;
    rst_q <= reset;
    pal_q <= pal_mode;
  end
  always @(negedge clock) begin
    if (rst_q) begin
      chk("reset_pos", {xPos, yPos}, 0);
      chk("reset_frame", {oddFrame, frameCount}, 0);
      chk("reset_pal", palActive, pal_q);
      chk("reset_strobes", strobes, 0);
      acc = '{default: 0};
      prev_fc = 0;
    end else if (!en_q) begin
      chk("hold", outs, snap);
    end else begin
      acc.len++;
      acc.idle += int'(idle);
      acc.incx += int'(incrementX);
      acc.incy += int'(incrementY);
      acc.rstx += int'(resetX);
      acc.rsty += int'(resetY);
      acc.bgf += int'(backgroundFetch_EN);
      acc.spf += int'(spriteFetch_EN);
      if (setVBlank) begin
        acc.setvb++;
        acc.sv_pos = int'(yPos) * 1000 + int'(xPos);
      end
      if (clearVBlank) begin
        acc.clrvb++;
        acc.cv_pos = int'(yPos) * 1000 + int'(xPos);
      end
      if (lineMatch) begin
        acc.match++;
        acc.lm_pos = int'(yPos) * 1000 + int'(xPos);
      end
      if (int'(frameCount) != prev_fc) begin
        acc.x_after = int'(xPos);
        acc.fc = int'(frameCount);
        acc.odd = int'(oddFrame);
        acc.pal = int'(palActive);
        if (q.size() == 0) chk("unexpected_wrap", frameCount, prev_fc);
        else cmp_frame(acc, q.pop_front());
        acc = '{default: 0};
        prev_fc = int'(frameCount);
      end
    end
    snap = outs;
  end
  task automatic do_reset(bit pal);
    @(negedge clock);
    reset = 1'b1;
    clock_EN = 1'b0;
    pal_mode = pal;
    @(negedge clock);
    reset = 1'b0;
    clock_EN = 1'b1;
  endtask
  task automatic run_frames(int budget, bit gaps);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clock);
      clock_EN = gaps ? ($urandom_range(3) != 0) : 1'b1;
      n++;
    end
    clock_EN = 1'b1;
    if (q.size() != 0) begin
      chk("frame_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic wait_pos(int wx, int wy, int budget);
    int n = 0;
    while (!(int'(xPos) == wx && int'(yPos) == wy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) chk("pos_timeout", {yPos, xPos}, wy * 512 + wx);
  endtask
  initial begin
    background_EN = 1'b1;
    sprite_EN = 1'b1;
    cmp_EN = 1'b1;
    cmp_line = 9'd4;
    do_reset(1'b0);
    q.push_back(ef(NL, 1, 1, 0, 4, 1, 1, 0, 0));
    q.push_back(ef(NL, 1, 1, 0, 4, 2, 0, 0, 1));
    q.push_back(ef(NL, 1, 1, 1, 4, 3, 1, 0, 0));
    run_frames(12000, 1'b0);
    sprite_EN = 1'b0;
    cmp_line = 9'd9;
    do_reset(1'b0);
    q.push_back(ef(NL, 1, 0, 0, -1, 1, 1, 0, 0));
    run_frames(4000, 1'b0);
    background_EN = 1'b0;
    cmp_line = 9'd4;
    do_reset(1'b0);
    q.push_back(ef(NL, 0, 0, 0, -1, 1, 1, 0, 0));
    q.push_back(ef(NL, 0, 0, 0, -1, 2, 0, 0, 0));
    run_frames(7000, 1'b0);
    background_EN = 1'b1;
    cmp_line = 9'd9;
    do_reset(1'b0);
    q.push_back(ef(NL, 1, 0, 0, -1, 1, 1, 1, 0));
    q.push_back(ef(PL, 1, 0, 0, 9, 2, 0, 1, 0));
    q.push_back(ef(PL, 1, 0, 0, 9, 3, 1, 1, 0));
    wait_pos(0, 4, 3000);
    pal_mode = 1'b1;
    run_frames(20000, 1'b1);
    sprite_EN = 1'b1;
    cmp_EN = 1'b0;
    do_reset(1'b0);
    wait_pos(150, 5, 3000);
    clock_EN = 1'b0;
    @(negedge clock);
    do_reset(1'b1);
    q.push_back(ef(PL, 1, 1, 0, -1, 1, 1, 1, 0));
    run_frames(5000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
